// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier, unsigned or two's-complement per operation.
// Latency: start edge to done pulse is WIDTH+1 edges; one multiplier bit is consumed per clock.
// Backpressure: none; start is ignored while busy, and product holds until the next completion.
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   start,
    input  logic                   signed_mode,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Step index on which the multiplier MSB is processed.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;
    logic             sgn_r;

    logic [WIDTH:0]   hi_x;
    logic [WIDTH:0]   m_x;
    logic [WIDTH:0]   sum;

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    // One shift-add step at WIDTH+1 bits; in signed mode the MSB of the
    // multiplier carries negative weight, so its partial product is subtracted.
    always_comb begin
        hi_x = {sgn_r & hi[WIDTH-1], hi};
        m_x  = {sgn_r & m_r[WIDTH-1], m_r};
        sum  = hi_x;
        if (lo[0]) begin
            if (sgn_r && (cnt == LAST_STEP)) begin
                sum = hi_x - m_x;
            end else begin
                sum = hi_x + m_x;
            end
        end
    end

    // Control and datapath registers; product only moves on the final step.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= ST_IDLE;
            m_r     <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            sgn_r   <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_r   <= multiplicand;
                        lo    <= multiplier;
                        hi    <= '0;
                        cnt   <= '0;
                        sgn_r <= signed_mode;
                        state <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    hi  <= sum[WIDTH:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        product <= {sum, lo[WIDTH-1:1]};
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        clear_n;

    logic        s4, sg4;
    logic [3:0]  m4, q4;
    logic        b4, d4;
    logic [7:0]  p4;

    logic        s8, sg8;
    logic [7:0]  m8, q8;
    logic        b8, d8;
    logic [15:0] p8;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(4)) u_w4 (
        .clk(clk), .clear_n(clear_n), .start(s4), .signed_mode(sg4),
        .multiplicand(m4), .multiplier(q4), .busy(b4), .done(d4), .product(p4)
    );

    seq_mult_param #(.WIDTH(8)) u_w8 (
        .clk(clk), .clear_n(clear_n), .start(s8), .signed_mode(sg8),
        .multiplicand(m8), .multiplier(q8), .busy(b8), .done(d8), .product(p8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic int wid(input int inst);
        return (inst == 0) ? 4 : 8;
    endfunction

    // Plain arithmetic reference: interpret operands, multiply, wrap to 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input bit sg,
                                            input logic [7:0] m, input logic [7:0] q);
        longint mv, qv, p, mask;
        mask = (longint'(1) << w) - 1;
        mv = longint'(m) & mask;
        qv = longint'(q) & mask;
        if (sg && m[w-1]) mv = mv - (longint'(1) << w);
        if (sg && q[w-1]) qv = qv - (longint'(1) << w);
        p = mv * qv;
        return 16'(p & ((longint'(1) << (2*w)) - 1));
    endfunction

    // Timeline model: an accepted start at edge a means busy after edges
    // a..a+w-1, done after edge a+w, and the new product appears at a+w.
    int          ecnt = 0;
    int          acc[2];
    bit          have[2];
    logic [15:0] pend[2];
    logic [15:0] mprod[2];
    bit          mbusy[2];
    bit          mdone[2];
    bit          md_st, md_sg, md_was_busy;
    logic [7:0]  md_m, md_q;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 2; i++) begin
                have[i] = 1'b0; mprod[i] = '0; mbusy[i] = 1'b0; mdone[i] = 1'b0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin md_st = s4; md_sg = sg4; md_m = {4'd0, m4}; md_q = {4'd0, q4}; end
                else        begin md_st = s8; md_sg = sg8; md_m = m8;          md_q = q8;          end
                if (have[i] && ecnt == acc[i] + wid(i)) mprod[i] = pend[i];
                md_was_busy = have[i] && (ecnt - 1 >= acc[i]) && (ecnt - 1 <= acc[i] + wid(i) - 1);
                if (!md_was_busy && md_st) begin
                    acc[i]  = ecnt;
                    have[i] = 1'b1;
                    pend[i] = ref_mul(wid(i), md_sg, md_m, md_q);
                end
                mbusy[i] = have[i] && ecnt >= acc[i] && ecnt <= acc[i] + wid(i) - 1;
                mdone[i] = have[i] && ecnt == acc[i] + wid(i);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy4", b4, mbusy[0]);
            chk("done4", d4, mdone[0]);
            chk("prod4", p4, mprod[0][7:0]);
            chk("busy8", b8, mbusy[1]);
            chk("done8", d8, mdone[1]);
            chk("prod8", p8, mprod[1]);
        end
    end

    task automatic set_in(input int inst, input bit st, input bit sg,
                          input logic [7:0] m, input logic [7:0] q);
        if (inst == 0) begin s4 = st; sg4 = sg; m4 = m[3:0]; q4 = q[3:0]; end
        else           begin s8 = st; sg8 = sg; m8 = m;      q8 = q;      end
    endtask

    function automatic bit dn(input int inst);
        return (inst == 0) ? d4 : d8;
    endfunction

    function automatic bit bs(input int inst);
        return (inst == 0) ? b4 : b8;
    endfunction

    function automatic logic [15:0] pr(input int inst);
        return (inst == 0) ? {8'd0, p4} : p8;
    endfunction

    // Single operation with a one-cycle start pulse; operands are scrambled afterwards.
    task automatic run_op(input int inst, input bit sg, input logic [7:0] m,
                          input logic [7:0] q, input logic [15:0] lit, input string name);
        int lat, bcnt;
        bit seen;
        @(negedge clk);
        set_in(inst, 1'b1, sg, m, q);
        lat = 0; bcnt = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) set_in(inst, 1'b0, ~sg, ~m, q ^ 8'h5A);
            if (bs(inst)) bcnt++;
            if (dn(inst)) seen = 1'b1;
        end
        chk({name, "_latency"}, lat, wid(inst) + 1);
        chk({name, "_busy_cycles"}, bcnt, wid(inst));
        chk({name, "_product"}, pr(inst), lit);
        chk({name, "_model"}, mprod[inst], lit);
    endtask

    logic [7:0]  bm[3]   = '{8'h12, 8'hF0, 8'hC8};
    logic [7:0]  bq[3]   = '{8'h34, 8'h10, 8'h03};
    bit          bsg[3]  = '{1'b0, 1'b1, 1'b0};
    logic [15:0] bexp[3] = '{16'h03A8, 16'hFF00, 16'h0258};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, last, k, lat;
        bit seen;

        clear_n = 1'b1;
        set_in(0, 1'b0, 1'b0, 8'h0, 8'h0);
        set_in(1, 1'b0, 1'b0, 8'h0, 8'h0);
        #1 clear_n = 1'b0;
        #2;
        cmp_en = 1'b1;
        chk("rst_busy8", b8, 0);
        chk("rst_done8", d8, 0);
        chk("rst_prod8", p8, 0);
        chk("rst_prod4", p4, 0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;

        run_op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, "u4_15x15");
        run_op(0, 1'b1, 8'h0D, 8'h05, 16'h00F1, "s4_m3x5");
        run_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, "s4_m8xm8");
        run_op(0, 1'b1, 8'h07, 8'h0F, 16'h00F9, "s4_7xm1");

        run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u8_255x255");
        run_op(1, 1'b1, 8'hFF, 8'hFF, 16'h0001, "s8_m1xm1");
        run_op(1, 1'b0, 8'h00, 8'hA5, 16'h0000, "u8_zero");
        run_op(1, 1'b1, 8'h00, 8'hA5, 16'h0000, "s8_zero_m");
        run_op(1, 1'b1, 8'hA5, 8'h00, 16'h0000, "s8_zero_q");

        // start held high across three operations on the 8-bit unit
        @(negedge clk);
        set_in(1, 1'b1, bsg[0], bm[0], bq[0]);
        cyc = 0; last = 0; k = 0;
        while (k < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (d8) begin
                chk("b2b_product", p8, bexp[k]);
                chk("b2b_spacing", cyc - last, 9);
                last = cyc;
                k++;
                if (k < 3) set_in(1, 1'b1, bsg[k], bm[k], bq[k]);
                else       set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        chk("b2b_count", k, 3);

        // start pulsed mid-operation with different operands must be ignored
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 8'h09, 8'h07);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
            if (lat == 2) set_in(0, 1'b1, 1'b1, 8'h03, 8'h03);
            if (lat == 3) set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
            if (d4) seen = 1'b1;
        end
        chk("ignore_start_latency", lat, 5);
        chk("ignore_start_product", p4, 8'h3F);

        // asynchronous clear during the calculation
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 8'hFF, 8'h02);
        @(negedge clk);
        set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2 clear_n = 1'b0;
        #1;
        chk("clr_busy8", b8, 0);
        chk("clr_done8", d8, 0);
        chk("clr_prod8", p8, 0);
        chk("clr_prod4", p4, 0);
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (d8 || b8) seen = 1'b1;
        end
        chk("clr_no_done", seen, 0);
        run_op(1, 1'b1, 8'hFE, 8'h03, 16'hFFFA, "s8_after_clear");

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
